// File: rtl/vga_timing_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing_decoder                                                       |
// | Recovers x/y/de from a pixel-strobed VGA stream; tracks lock and errors. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vga_timing_decoder #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_pix_en,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic [2:0] i_rgb,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_de,
    output logic [2:0] o_pix_rgb,
    output logic       o_locked,
    output logic       o_frame_start,
    output logic       o_timing_err,
    output logic [7:0] o_err_count
);

    localparam int c_H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_H_SYNC_START = H_ACTIVE + H_FP;
    localparam int c_V_SYNC_START = V_ACTIVE + V_FP;
    localparam int c_WD_W         = $clog2(WDOG_LIMIT + 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t            r_state;
    logic [9:0]        r_h_cnt;
    logic [9:0]        r_v_cnt;
    logic [c_WD_W-1:0] r_wdog;
    logic              r_hs_prev;
    logic              r_vs_prev;
    logic              r_locked;
    logic              r_de;
    logic [2:0]        r_pix_rgb;
    logic              r_frame_start;
    logic              r_timing_err;
    logic [7:0]        r_err_count;

    logic              w_hs_fall;
    logic              w_vs_fall;
    logic              w_h_wrap;
    logic [9:0]        w_h_pred;
    logic [9:0]        w_v_pred;
    logic [9:0]        w_h_new;
    logic [9:0]        w_v_new;
    logic [c_WD_W-1:0] w_wdog_inc;
    logic              w_timeout;
    logic              w_h_err;
    logic              w_v_err;
    logic              w_err;
    logic              w_lock_next;
    logic              w_de_new;

    assign w_hs_fall = r_hs_prev & ~i_hsync;
    assign w_vs_fall = r_vs_prev & ~i_vsync;

    // Free-running prediction; sync edges then snap the counters to their nominal position.
    assign w_h_wrap = (r_h_cnt == 10'(c_H_TOTAL - 1));
    assign w_h_pred = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
    assign w_v_pred = !w_h_wrap ? r_v_cnt :
                      (r_v_cnt == 10'(c_V_TOTAL - 1)) ? 10'd0 : r_v_cnt + 10'd1;
    assign w_h_new  = w_hs_fall ? 10'(c_H_SYNC_START) : w_h_pred;
    assign w_v_new  = w_vs_fall ? 10'(c_V_SYNC_START) : w_v_pred;

    assign w_wdog_inc = r_wdog + c_WD_W'(1);
    assign w_timeout  = ~w_hs_fall & (w_wdog_inc == c_WD_W'(WDOG_LIMIT));

    assign w_h_err = w_hs_fall & (w_h_pred != 10'(c_H_SYNC_START));
    assign w_v_err = w_vs_fall & (w_v_pred != 10'(c_V_SYNC_START));
    assign w_err   = (w_h_err | w_v_err | w_timeout) & (r_state != SEARCH);

    // de must fall in the same output cycle as the error that breaks lock.
    assign w_lock_next = ~w_err & ((r_state == LOCKED) | ((r_state == ACQUIRE) & w_vs_fall));
    assign w_de_new    = w_lock_next & (w_h_new < 10'(H_ACTIVE)) & (w_v_new < 10'(V_ACTIVE));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= SEARCH;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_wdog        <= '0;
            r_hs_prev     <= 1'b1;
            r_vs_prev     <= 1'b1;
            r_locked      <= 1'b0;
            r_de          <= 1'b0;
            r_pix_rgb     <= 3'b000;
            r_frame_start <= 1'b0;
            r_timing_err  <= 1'b0;
            r_err_count   <= 8'd0;
        end else begin
            r_frame_start <= 1'b0;
            r_timing_err  <= 1'b0;
            if (i_pix_en) begin
                r_hs_prev <= i_hsync;
                r_vs_prev <= i_vsync;
                r_h_cnt   <= w_h_new;
                r_v_cnt   <= w_v_new;
                r_wdog    <= (w_hs_fall | w_timeout) ? '0 : w_wdog_inc;

                case (r_state)
                    SEARCH:  if (w_vs_fall) r_state <= ACQUIRE;
                    ACQUIRE: begin
                        if (w_err)          r_state <= SEARCH;
                        else if (w_vs_fall) r_state <= LOCKED;
                    end
                    LOCKED:  if (w_err) r_state <= SEARCH;
                    default: r_state <= SEARCH;
                endcase

                r_locked      <= w_lock_next;
                r_de          <= w_de_new;
                r_pix_rgb     <= w_de_new ? i_rgb : 3'b000;
                r_frame_start <= w_de_new & (w_h_new == 10'd0) & (w_v_new == 10'd0);
                r_timing_err  <= w_err;
                if (w_err && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign o_x           = r_h_cnt;
    assign o_y           = r_v_cnt;
    assign o_de          = r_de;
    assign o_pix_rgb     = r_pix_rgb;
    assign o_locked      = r_locked;
    assign o_frame_start = r_frame_start;
    assign o_timing_err  = r_timing_err;
    assign o_err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_timing_decoder                                                    |
// | Scoreboard bench with a reduced raster; reference model from the rules.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vga_timing_decoder;

    // Reduced raster keeps full frames cheap; the rules are size-independent.
    localparam int HA = 16, HF = 2, HS = 4, HB = 2;
    localparam int VA = 8,  VF = 2, VS = 1, VB = 2;
    localparam int WD  = 32;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam int HSS = HA + HF;
    localparam int VSS = VA + VF;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       pix_en = 1'b0;
    logic       hsync  = 1'b1;
    logic       vsync  = 1'b1;
    logic [2:0] rgb    = 3'b000;
    logic [9:0] o_x;
    logic [9:0] o_y;
    logic       o_de;
    logic [2:0] o_pix_rgb;
    logic       o_locked;
    logic       o_frame_start;
    logic       o_timing_err;
    logic [7:0] o_err_count;

    vga_timing_decoder #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .WDOG_LIMIT(WD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_pix_en     (pix_en),
        .i_hsync      (hsync),
        .i_vsync      (vsync),
        .i_rgb        (rgb),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_de         (o_de),
        .o_pix_rgb    (o_pix_rgb),
        .o_locked     (o_locked),
        .o_frame_start(o_frame_start),
        .o_timing_err (o_timing_err),
        .o_err_count  (o_err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic [2:0] rgb;
        logic       locked;
        logic       fs;
        logic       terr;
        logic [7:0] ec;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   tb_arm   = 1'b0;
    bit   tb_present = 1'b0;
    int   de_seen  = 0;
    int   fs_seen  = 0;

    string       dreq_name = "";
    logic [63:0] dreq_got  = '0;
    logic [63:0] dreq_exp  = '0;
    int          dreq_seq  = 0;
    int          dreq_done = 0;

    // Reference model state: mode 0 = searching, 1 = acquiring, 2 = locked.
    int m_h = 0, m_v = 0, m_wd = 0, m_mode = 0, m_ec = 0;
    bit m_hsp = 1'b1, m_vsp = 1'b1;

    function automatic obs_t model_step(bit rstn, bit hs, bit vs, logic [2:0] c);
        obs_t o;
        bit hfall, vfall, herr, verr, tmo, err;
        int ph, pv;
        o = '0;
        if (!rstn) begin
            m_h = 0; m_v = 0; m_wd = 0; m_mode = 0; m_ec = 0; m_hsp = 1'b1; m_vsp = 1'b1;
            return o;
        end
        hfall = m_hsp && !hs;
        vfall = m_vsp && !vs;
        m_hsp = hs;
        m_vsp = vs;
        ph    = (m_h + 1) % HT;
        pv    = (ph == 0) ? (m_v + 1) % VT : m_v;
        herr  = hfall && (ph != HSS);
        verr  = vfall && (pv != VSS);
        m_wd  = hfall ? 0 : m_wd + 1;
        tmo   = (m_wd == WD);
        if (tmo) m_wd = 0;
        m_h   = hfall ? HSS : ph;
        m_v   = vfall ? VSS : pv;
        err   = (herr || verr || tmo) && (m_mode != 0);
        if (err) m_mode = 0;
        else if (vfall && m_mode < 2) m_mode = m_mode + 1;
        if (err && m_ec < 255) m_ec = m_ec + 1;
        o.x      = 10'(m_h);
        o.y      = 10'(m_v);
        o.locked = (m_mode == 2);
        o.de     = o.locked && (m_h < HA) && (m_v < VA);
        o.rgb    = o.de ? c : 3'b000;
        o.fs     = o.de && (m_h == 0) && (m_v == 0);
        o.terr   = err;
        o.ec     = 8'(m_ec);
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("x=%0d y=%0d de=%0b rgb=%0d locked=%0b fs=%0b terr=%0b ec=%0d",
                         o.x, o.y, o.de, o.rgb, o.locked, o.fs, o.terr, o.ec);
    endfunction

    always @(posedge clk) tb_present <= tb_arm && (!rst || pix_en);

    // Monitor: pops one expectation per output update, checks hold otherwise.
    obs_t last_exp  = '0;
    bit   have_last = 1'b0;
    always @(negedge clk) begin
        obs_t got;
        obs_t e;
        got = {o_x, o_y, o_de, o_pix_rgb, o_locked, o_frame_start, o_timing_err, o_err_count};
        if (tb_present) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: output update with no expectation, got %s", fmt(got));
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL sb_output @%0t: got %s, expected %s", $time, fmt(got), fmt(e));
                end
                last_exp      = e;
                last_exp.fs   = 1'b0;
                last_exp.terr = 1'b0;
                have_last     = 1'b1;
            end
            if (o_de) de_seen++;
            if (o_frame_start) fs_seen++;
        end else if (have_last) begin
            n_checks++;
            if (got !== last_exp) begin
                n_fail++;
                $display("FAIL sb_hold @%0t: got %s, expected %s", $time, fmt(got), fmt(last_exp));
            end
        end
        if (dreq_seq != dreq_done) begin
            dreq_done = dreq_seq;
            n_checks++;
            if (dreq_got !== dreq_exp) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", dreq_name, dreq_got, dreq_exp);
            end
        end
    end

    task automatic drive(input bit rstn, input bit pe, input bit hs, input bit vs, input logic [2:0] c);
        @(negedge clk);
        rst    = rstn;
        pix_en = pe;
        hsync  = hs;
        vsync  = vs;
        rgb    = c;
        tb_arm = 1'b1;
        if (!rstn || pe) exp_q.push_back(model_step(rstn, hs, vs, c));
    endtask

    task automatic pixel(input bit hs, input bit vs, input logic [2:0] c, input int gap);
        for (int i = 0; i < gap; i++) drive(1'b1, 1'b0, 1'($urandom), 1'($urandom), 3'($urandom));
        drive(1'b1, 1'b1, hs, vs, c);
    endtask

    task automatic settle();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b000);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b000);
    endtask

    task automatic dcheck(input string name, input logic [63:0] got, input logic [63:0] exp);
        dreq_name = name;
        dreq_got  = got;
        dreq_exp  = exp;
        dreq_seq++;
        settle();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
    endtask

    task automatic frame(input int gmin, input int gmax, input int long_line, input bit fixed_rgb);
        int         len;
        bit         hs, vs;
        logic [2:0] c;
        for (int v = 0; v < VT; v++) begin
            len = (v == long_line) ? HT + 1 : HT;
            for (int h = 0; h < len; h++) begin
                hs = !(h >= HSS && h < HSS + HS);
                vs = !(v >= VSS && v < VSS + VS);
                c  = fixed_rgb ? 3'b101 : 3'($urandom);
                pixel(hs, vs, c, int'($urandom_range(gmax, gmin)));
            end
        end
    endtask

    initial begin
        int de0, fs0, ec0;
        do_reset(3);
        settle();
        dcheck("reset_outputs", 64'({o_x, o_y, o_de, o_pix_rgb, o_locked, o_frame_start,
                                     o_timing_err, o_err_count}), 64'd0);

        frame(3, 3, -1, 1'b0);
        settle();
        dcheck("locked_after_frame1", 64'(o_locked), 64'd0);
        frame(3, 3, -1, 1'b0);
        settle();
        dcheck("locked_after_frame2", 64'(o_locked), 64'd1);

        de0 = de_seen; fs0 = fs_seen;
        frame(3, 3, -1, 1'b0);
        settle();
        dcheck("de_pixels_per_frame", 64'(de_seen - de0), 64'(HA * VA));
        dcheck("frame_starts_per_frame", 64'(fs_seen - fs0), 64'd1);

        frame(0, 3, -1, 1'b1);
        frame(0, 3, 3, 1'b0);
        settle();
        dcheck("err_count_after_long_line", 64'(o_err_count), 64'd1);
        dcheck("locked_after_long_line", 64'(o_locked), 64'd0);
        frame(0, 3, -1, 1'b0);
        settle();
        dcheck("relocked_after_long_line", 64'(o_locked), 64'd1);

        for (int i = 0; i < 40; i++) pixel(1'b1, 1'b1, 3'($urandom), int'($urandom_range(2, 0)));
        settle();
        dcheck("err_count_after_timeout", 64'(o_err_count), 64'd2);
        dcheck("locked_after_timeout", 64'(o_locked), 64'd0);

        frame(0, 2, -1, 1'b0);
        frame(0, 2, -1, 1'b0);
        settle();
        dcheck("relocked_before_reset", 64'(o_locked), 64'd1);
        do_reset(2);
        settle();
        dcheck("lock_and_count_after_reset", 64'({o_locked, o_err_count}), 64'd0);

        for (int i = 0; i < 300; i++)
            pixel(($urandom % 8) != 0, ($urandom % 16) != 0, 3'($urandom), int'($urandom_range(2, 0)));

        do_reset(2);
        pixel(1'b1, 1'b1, 3'b000, 0);
        pixel(1'b0, 1'b0, 3'b000, 0);
        for (int i = 0; i < 6; i++) pixel(1'b1, 1'b1, 3'b000, 0);
        pixel(1'b0, 1'b0, 3'b000, 0);
        settle();
        ec0 = int'(o_err_count);
        dcheck("simultaneous_hv_counts_once", 64'(ec0), 64'd1);

        for (int i = 0; i < 300; i++) begin
            pixel(1'b1, 1'b1, 3'($urandom), int'($urandom_range(1, 0)));
            pixel(1'b0, 1'b0, 3'($urandom), int'($urandom_range(1, 0)));
            pixel(1'b1, 1'b1, 3'($urandom), int'($urandom_range(1, 0)));
            pixel(1'b0, 1'b0, 3'($urandom), int'($urandom_range(1, 0)));
        end
        settle();
        dcheck("err_count_saturated", 64'(o_err_count), 64'd255);
        dcheck("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
